// File: rtl/sid_write_scheduler.sv
// UART byte framer + 4-entry write FIFO + phi2-aligned dispatcher feeding two SIDs.
// Both SIDs share one phi2 enable; each write is held for one full phi2 period.
module sid_write_scheduler #(
  parameter int PHI2_DIV       = 12,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int FIFO_AW        = 2
) (
  input  logic       CLK_IN,
  input  logic       RSTn_i,
  input  logic       RX_VALID_i,
  input  logic [7:0] RX_DATA_i,
  output logic       PHI2_EN_o,
  output logic       SID0_CS_o,
  output logic       SID1_CS_o,
  output logic       SID_WE_o,
  output logic [4:0] SID_ADDR_o,
  output logic [7:0] SID_DATA_o,
  output logic       FIFO_FULL_o,
  output logic [7:0] DROP_CNT_o,
  output logic       BUSY_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNTW  = FIFO_AW + 1;
  localparam int CW    = $clog2(PHI2_DIV);
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       chip;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef enum logic {S_ADDR, S_DATA} state_t;

  // phi2 generator
  logic [CW-1:0] ph_q, ph_d;
  logic          phi2;
  assign phi2 = (ph_q == CW'(PHI2_DIV - 1));
  assign ph_d = phi2 ? '0 : ph_q + CW'(1);

  // framer
  state_t        st_q, st_d;
  logic          chip_q, chip_d;
  logic [4:0]    reg_q, reg_d;
  logic [TW-1:0] to_q, to_d;
  logic          push, fr_drop;

  always_comb begin
    st_d    = st_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    to_d    = to_q;
    push    = 1'b0;
    fr_drop = 1'b0;
    case (st_q)
      S_ADDR: if (RX_VALID_i) begin
        if (RX_DATA_i[7:6] == 2'b00) begin
          chip_d = RX_DATA_i[5];
          reg_d  = RX_DATA_i[4:0];
          to_d   = '0;
          st_d   = S_DATA;
        end else begin
          fr_drop = 1'b1;
        end
      end
      S_DATA: begin
        // a byte arriving on the timeout cycle still completes the pair
        if (RX_VALID_i) begin
          push = 1'b1;
          st_d = S_ADDR;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fr_drop = 1'b1;
          st_d    = S_ADDR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: st_d = S_ADDR;
    endcase
  end

  // FIFO
  wr_t                mem [DEPTH];
  wr_t                push_ent, head;
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               empty, full, pop, push_ok, ff_drop;

  assign push_ent = '{chip: chip_q, addr: reg_q, data: RX_DATA_i};
  assign head     = mem[rp_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNTW'(DEPTH));
  assign pop      = phi2 && !empty;
  assign push_ok  = push && (!full || pop);
  assign ff_drop  = push && full && !pop;

  always_comb begin
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (push_ok) mem[wp_q] <= push_ent;
  end

  // dispatcher: loads only on phi2, so each write spans exactly one period
  logic       we_q, we_d, cs0_q, cs0_d, cs1_q, cs1_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, drop_q, drop_d;
  logic       full_q, busy_q;

  always_comb begin
    we_d   = we_q;
    cs0_d  = cs0_q;
    cs1_d  = cs1_q;
    addr_d = addr_q;
    data_d = data_q;
    if (phi2) begin
      if (!empty) begin
        we_d   = 1'b1;
        cs0_d  = ~head.chip;
        cs1_d  = head.chip;
        addr_d = head.addr;
        data_d = head.data;
      end else begin
        we_d  = 1'b0;
        cs0_d = 1'b0;
        cs1_d = 1'b0;
      end
    end
  end

  assign drop_d = ((fr_drop || ff_drop) && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) begin
      ph_q   <= '0;
      st_q   <= S_ADDR;
      chip_q <= 1'b0;
      reg_q  <= '0;
      to_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      cs0_q  <= 1'b0;
      cs1_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      drop_q <= '0;
      full_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      st_q   <= st_d;
      chip_q <= chip_d;
      reg_q  <= reg_d;
      to_q   <= to_d;
      if (push_ok) wp_q <= wp_q + FIFO_AW'(1);
      if (pop)     rp_q <= rp_q + FIFO_AW'(1);
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      cs0_q  <= cs0_d;
      cs1_q  <= cs1_d;
      addr_q <= addr_d;
      data_q <= data_d;
      drop_q <= drop_d;
      full_q <= (cnt_d == CNTW'(DEPTH));
      busy_q <= (cnt_d != '0) || we_d;
    end
  end

  assign PHI2_EN_o   = phi2;
  assign SID_WE_o    = we_q;
  assign SID0_CS_o   = cs0_q;
  assign SID1_CS_o   = cs1_q;
  assign SID_ADDR_o  = addr_q;
  assign SID_DATA_o  = data_q;
  assign FIFO_FULL_o = full_q;
  assign DROP_CNT_o  = drop_q;
  assign BUSY_o      = busy_q;
endmodule

// File: tb/tb_sid_write_scheduler.sv
// Directed bench for sid_write_scheduler: phi2 cadence, framing, timeout, FIFO overflow, reset.
module tb_sid_write_scheduler;
  logic       clk, rst_n, rx_vld;
  logic [7:0] rx_dat;
  logic       phi2, cs0, cs1, we, full, busy;
  logic [4:0] addr;
  logic [7:0] data, drop;

  int n_chk = 0;
  int n_bad = 0;
  int exp_drop = 0;

  sid_write_scheduler dut (
    .CLK_IN(clk), .RSTn_i(rst_n), .RX_VALID_i(rx_vld), .RX_DATA_i(rx_dat),
    .PHI2_EN_o(phi2), .SID0_CS_o(cs0), .SID1_CS_o(cs1), .SID_WE_o(we),
    .SID_ADDR_o(addr), .SID_DATA_o(data), .FIFO_FULL_o(full),
    .DROP_CNT_o(drop), .BUSY_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_vld = 1'b1;
    rx_dat = b;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic chip, input logic [4:0] a,
                              input logic [7:0] d);
    int w;
    int n;
    w = 0;
    while (!we && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_we"}, we, 1'b1);
    if (we) begin
      chk({tag, "_cs"}, {cs1, cs0}, {chip, ~chip});
      chk({tag, "_addr"}, addr, a);
      chk({tag, "_data"}, data, d);
      n = 0;
      while (we && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk({tag, "_len"}, n, 12);
    end
  endtask

  // pairs: {addr byte, data byte}
  logic [7:0] bb [12] = '{8'h01, 8'h11, 8'h22, 8'h22, 8'h03, 8'h33,
                          8'h24, 8'h44, 8'h05, 8'h55, 8'h26, 8'h66};

  initial begin
    int w;
    int seen;
    logic [7:0] ab;
    rst_n  = 1'b0;
    rx_vld = 1'b0;
    rx_dat = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outs", {phi2, cs0, cs1, we, addr, data, full, drop, busy}, '0);

    // idle cadence: after k edges the phase counter is k mod 12
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("phi2_k%0d", k), phi2, (k % 12) == 11);
    end
    chk("idle_sid", {we, cs0, cs1, busy}, '0);

    send_byte(8'h18);
    send_byte(8'h0F);
    expect_write("w_sid0", 1'b0, 5'h18, 8'h0F);

    send_byte(8'h21);
    send_byte(8'h07);
    expect_write("w_sid1", 1'b1, 5'h01, 8'h07);

    // timeout lands exactly 12000 edges after the address byte
    send_byte(8'h05);
    repeat (11999) @(negedge clk);
    chk("to_edge_m1", drop, exp_drop);
    @(negedge clk);
    exp_drop++;
    chk("to_edge", drop, exp_drop);
    send_byte(8'h55);
    exp_drop++;
    chk("bad_addr", drop, exp_drop);
    send_byte(8'h06);
    send_byte(8'hF5);
    expect_write("w_resync", 1'b0, 5'h06, 8'hF5);

    // data byte on the timeout cycle wins
    send_byte(8'h07);
    repeat (11999) @(negedge clk);
    send_byte(8'h99);
    chk("to_race_drop", drop, exp_drop);
    expect_write("w_race", 1'b0, 5'h07, 8'h99);

    // burst: first byte sampled on a phi2 edge E0; pushes at E0+2,6,..,22.
    // The E0+12 pop drains one entry, so pairs 1-5 fit and pair 6 overflows.
    w = 0;
    while (!phi2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("burst_sync", phi2, 1'b1);
    for (int j = 0; j < 80; j++) begin
      if (j == 17) chk("burst_full_3", full, 1'b0);
      if (j == 19) chk("burst_full_4", full, 1'b1);
      if (j == 23) begin
        exp_drop++;
        chk("burst_drop", drop, exp_drop);
        chk("burst_full_hold", full, 1'b1);
      end
      if (j == 25) chk("burst_full_pop", full, 1'b0);
      if (j >= 18 && j <= 66 && (j - 6) % 12 == 0) begin
        ab = bb[2 * ((j - 6) / 12 - 1)];
        chk($sformatf("burst_we_%0d", j), we, 1'b1);
        chk($sformatf("burst_cs_%0d", j), {cs1, cs0}, {ab[5], ~ab[5]});
        chk($sformatf("burst_ad_%0d", j), {addr, data}, {ab[4:0], bb[2 * ((j - 6) / 12) - 1]});
      end
      if (j == 73) chk("burst_end", {we, cs0, cs1, busy, full}, '0);
      if (j < 24 && j % 2 == 0) begin
        rx_vld = 1'b1;
        rx_dat = bb[j / 2];
      end else begin
        rx_vld = 1'b0;
      end
      @(negedge clk);
    end

    // reset three cycles into a write, with a second pair still queued
    send_byte(8'h0A);
    send_byte(8'h3C);
    send_byte(8'h2B);
    send_byte(8'h5A);
    w = 0;
    while (!we && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("rst_wr_active", we, 1'b1);
    chk("rst_q_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {we, cs0, cs1}, '0);
    exp_drop = 0;
    @(negedge clk);
    chk("rst_drop", drop, exp_drop);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (we) seen++;
    end
    chk("rst_no_wr", seen, 0);
    chk("rst_empty", {busy, full}, '0);

    // drop counter saturates
    rx_vld = 1'b1;
    rx_dat = 8'hC0;
    repeat (300) @(negedge clk);
    rx_vld = 1'b0;
    @(negedge clk);
    chk("drop_sat", drop, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
